// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding word read, fetched word handed to decode over valid/ready.
// Optional feature macro: YSYX_23060332_IFU_EBREAK_HALT_EN (stop fetching after an accepted ebreak).
module ysyx_23060332_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP,
        S_HALT
    } state_t;

`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] redirect_target;
    logic [31:0] pc_inc;
    logic        unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign pc_inc               = pc_q + 32'd4;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    // Redirect is checked first in every state so it overrides handshakes in the same cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = mem_req_ready ? S_DROP : S_REQ;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = mem_rsp_valid ? S_REQ : S_DROP;
                end else if (mem_rsp_valid) begin
                    inst_d    = mem_rsp_data;
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_inc;
                    state_d = S_REQ;
`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
                    if (inst_q == EBREAK) begin
                        state_d = S_HALT;
                    end
`endif
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (mem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == S_HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;

`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
